// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the vector reduction collector.
// Op encodings, FSM states, element sizes and the per-op identity byte.
package riscv_v_pkg;

    localparam int RISCV_V_NUM_BYTES_DATA = 16;

    typedef enum logic [1:0] {
        RED_OR  = 2'd0,
        RED_AND = 2'd1,
        RED_XOR = 2'd2
    } red_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REDUCE = 2'd2,
        HOLD   = 2'd3
    } red_state_e;

    typedef enum logic [1:0] {
        OSZ_8  = 2'd0,
        OSZ_16 = 2'd1,
        OSZ_32 = 2'd2,
        OSZ_64 = 2'd3
    } red_osize_e;

    function automatic logic [7:0] red_identity(input red_op_e op);
        return (op == RED_AND) ? 8'hFF : 8'h00;
    endfunction

    // The reserved encoding behaves as OR; the caller flags it separately.
    function automatic red_op_e red_op_decode(input logic [1:0] raw);
        case (raw)
            2'd1:    return RED_AND;
            2'd2:    return RED_XOR;
            default: return RED_OR;
        endcase
    endfunction

endpackage

// File: rtl/riscv_v_red_fold.sv
// Bytewise OR/AND/XOR of two byte vectors; masked-off bytes of b are
// replaced by the identity so they leave the corresponding byte of a intact.
module riscv_v_red_fold
    import riscv_v_pkg::*;
#(
    parameter int NUM_BYTES = RISCV_V_NUM_BYTES_DATA
) (
    input  red_op_e                    op,
    input  logic [NUM_BYTES*8-1:0]     a,
    input  logic [NUM_BYTES*8-1:0]     b,
    input  logic [NUM_BYTES-1:0]       mask,
    output logic [NUM_BYTES*8-1:0]     y
);

    logic [7:0] ident;
    assign ident = red_identity(op);

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            logic [7:0] a_b;
            logic [7:0] b_b;
            assign a_b = a[gi*8 +: 8];
            assign b_b = mask[gi] ? b[gi*8 +: 8] : ident;
            assign y[gi*8 +: 8] = (op == RED_AND) ? (a_b & b_b) :
                                  (op == RED_XOR) ? (a_b ^ b_b) :
                                                    (a_b | b_b);
        end
    endgenerate

endmodule

// File: rtl/riscv_v_red_accum.sv
// Collects vredor/vredand/vredxor ALU beats into a byte accumulator, halves it
// down to the element size, merges the vs1[0] seed and hands off one scalar.
module riscv_v_red_accum
    import riscv_v_pkg::*;
#(
    parameter int NUM_BYTES = RISCV_V_NUM_BYTES_DATA,
    parameter int MAX_BEATS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [1:0]                   op,
    input  logic [1:0]                   osize,
    input  logic [63:0]                  seed,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [NUM_BYTES*8-1:0]       in_data,
    input  logic [NUM_BYTES-1:0]         in_bmask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_data,
    output logic [$clog2(MAX_BEATS):0]   out_beats,
    output logic                         err
);

    localparam int DW = NUM_BYTES * 8;
    localparam int BW = $clog2(MAX_BEATS) + 1;
    localparam int HW = $clog2(NUM_BYTES) + 1;

    red_state_e        state_reg, state_next;
    logic [DW-1:0]     acc_reg, acc_next;
    red_op_e           op_reg, op_next;
    red_osize_e        osize_reg, osize_next;
    logic [63:0]       seed_reg, seed_next;
    logic [BW-1:0]     beats_reg, beats_next;
    logic [HW-1:0]     half_reg, half_next;
    logic              rdy_reg, rdy_next;
    logic              vld_reg, vld_next;
    logic              err_reg, err_next;
    logic [63:0]       out_data_reg, out_data_next;
    logic [BW-1:0]     out_beats_reg, out_beats_next;

    red_op_e           in_op, beat_op;
    logic [DW-1:0]     beat_a, beat_y, acc_hi, half_y;
    logic [HW-1:0]     elem_bytes;
    logic [63:0]       wmask, elem, seeded;
    logic              hs, take;

    assign in_op   = red_op_decode(op);
    // A first beat folds against the identity, which simply loads the masked beat.
    assign beat_op = in_first ? in_op : op_reg;
    assign beat_a  = in_first ? {NUM_BYTES{red_identity(in_op)}} : acc_reg;

    riscv_v_red_fold #(.NUM_BYTES(NUM_BYTES)) u_beat_fold (
        .op   (beat_op),
        .a    (beat_a),
        .b    (in_data),
        .mask (in_bmask),
        .y    (beat_y)
    );

    // Bytes above the active width go stale during halving but are never read.
    assign acc_hi = acc_reg >> {half_reg, 3'b000};

    riscv_v_red_fold #(.NUM_BYTES(NUM_BYTES)) u_half_fold (
        .op   (op_reg),
        .a    (acc_reg),
        .b    (acc_hi),
        .mask ({NUM_BYTES{1'b1}}),
        .y    (half_y)
    );

    assign elem_bytes = HW'(1) << osize_reg;

    always_comb begin
        case (osize_reg)
            OSZ_8:   wmask = 64'h0000_0000_0000_00FF;
            OSZ_16:  wmask = 64'h0000_0000_0000_FFFF;
            OSZ_32:  wmask = 64'h0000_0000_FFFF_FFFF;
            default: wmask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign elem = half_y[63:0] & wmask;

    always_comb begin
        case (op_reg)
            RED_AND: seeded = elem & seed_reg;
            RED_XOR: seeded = elem ^ seed_reg;
            default: seeded = elem | seed_reg;
        endcase
    end

    assign hs   = in_valid & rdy_reg;
    assign take = in_first | (state_reg == ACCUM);

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        op_next        = op_reg;
        osize_next     = osize_reg;
        seed_next      = seed_reg;
        beats_next     = beats_reg;
        half_next      = half_reg;
        rdy_next       = rdy_reg;
        vld_next       = vld_reg;
        err_next       = err_reg;
        out_data_next  = out_data_reg;
        out_beats_next = out_beats_reg;

        if (flush) begin
            state_next = IDLE;
            acc_next   = '0;
            beats_next = '0;
            rdy_next   = 1'b1;
            vld_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    rdy_next = 1'b1;
                    if (hs) begin
                        if (in_first) begin
                            acc_next   = beat_y;
                            op_next    = in_op;
                            osize_next = red_osize_e'(osize);
                            seed_next  = seed;
                            beats_next = BW'(1);
                            if (op == 2'd3 || state_reg == ACCUM) err_next = 1'b1;
                        end else if (state_reg == IDLE) begin
                            err_next = 1'b1;
                        end else begin
                            acc_next = beat_y;
                            if (beats_reg == BW'(MAX_BEATS)) begin
                                if (!in_last) err_next = 1'b1;
                            end else begin
                                beats_next = beats_reg + BW'(1);
                            end
                        end
                        if (take) begin
                            half_next = HW'(NUM_BYTES / 2);
                            if (in_last) begin
                                state_next = REDUCE;
                                rdy_next   = 1'b0;
                            end else begin
                                state_next = ACCUM;
                            end
                        end
                    end
                end
                REDUCE: begin
                    acc_next  = half_y;
                    half_next = half_reg >> 1;
                    if (half_reg == elem_bytes) begin
                        out_data_next  = seeded & wmask;
                        out_beats_next = beats_reg;
                        vld_next       = 1'b1;
                        state_next     = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        vld_next   = 1'b0;
                        rdy_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            op_reg        <= RED_OR;
            osize_reg     <= OSZ_8;
            seed_reg      <= '0;
            beats_reg     <= '0;
            half_reg      <= '0;
            rdy_reg       <= 1'b0;
            vld_reg       <= 1'b0;
            err_reg       <= 1'b0;
            out_data_reg  <= '0;
            out_beats_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            op_reg        <= op_next;
            osize_reg     <= osize_next;
            seed_reg      <= seed_next;
            beats_reg     <= beats_next;
            half_reg      <= half_next;
            rdy_reg       <= rdy_next;
            vld_reg       <= vld_next;
            err_reg       <= err_next;
            out_data_reg  <= out_data_next;
            out_beats_reg <= out_beats_next;
        end
    end

    // flush masks both handshakes in the cycle it is asserted.
    assign in_ready  = rdy_reg & ~flush;
    assign out_valid = vld_reg & ~flush;
    assign out_data  = out_data_reg;
    assign out_beats = out_beats_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_riscv_v_red_accum.sv
// Directed bench for riscv_v_red_accum: hand-computed results, latency,
// backpressure, protocol errors, flush and mid-operation reset.
module tb_riscv_v_red_accum;

    localparam int NB = 16;
    localparam int MB = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        op = 2'd0;
    logic [1:0]        osize = 2'd0;
    logic [63:0]       seed = 64'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic [NB*8-1:0]   in_data = '0;
    logic [NB-1:0]     in_bmask = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [63:0]       out_data;
    logic [3:0]        out_beats;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_v_red_accum #(.NUM_BYTES(NB), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .op        (op),
        .osize     (osize),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_bmask  (in_bmask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic f, input logic l, input logic [1:0] o, input logic [1:0] sz,
                        input logic [63:0] sd, input logic [NB*8-1:0] d, input logic [NB-1:0] m);
        int w = 0;
        in_first = f; in_last = l; op = o; osize = sz; seed = sd;
        in_data = d; in_bmask = m; in_valid = 1'b1;
        #0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        tick();
        $display("beat first=%0d last=%0d op=%0d osize=%0d data=%h mask=%h", f, l, o, sz, d, m);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    // Called one step after the last beat's accepting edge.
    task automatic expect_result(input int s, input logic [63:0] exp_data, input logic [3:0] exp_beats);
        for (int k = 0; k < s; k++) begin
            chk("out_valid_early", 64'(out_valid), 64'd0);
            chk("in_ready_reduce", 64'(in_ready), 64'd0);
            tick();
        end
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_data", out_data, exp_data);
        chk("out_beats", 64'(out_beats), 64'(exp_beats));
        $display("result data=%h beats=%0d expected data=%h beats=%0d", out_data, out_beats, exp_data, exp_beats);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_accept", 64'(out_valid), 64'd0);
        chk("in_ready_after_accept", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [NB*8-1:0] d;
        logic [NB*8-1:0] d2;

        // Reset values
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_beats", 64'(out_beats), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // OR, 8b, single beat
        for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'(1 << (i % 8));
        send(1'b1, 1'b1, 2'd0, 2'd0, 64'd0, d, '1);
        expect_result(4, 64'h0000_0000_0000_00FF, 4'd1);
        accept();

        // AND, 32b, two beats, second beat upper bytes masked
        d = '1;
        send(1'b1, 1'b0, 2'd1, 2'd2, 64'hFFFF_FFFF, d, '1);
        d[47:40] = 8'hEF;
        d[127:120] = 8'h00;
        send(1'b0, 1'b1, 2'd1, 2'd2, 64'd0, d, 16'h00FF);
        expect_result(2, 64'h0000_0000_FFFF_EFFF, 4'd2);
        accept();

        // XOR, 64b, all bytes masked off, then backpressure
        send(1'b1, 1'b0, 2'd2, 2'd3, 64'h1234, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, '0);
        send(1'b0, 1'b1, 2'd2, 2'd3, 64'd0, 128'hFFFF_0000_1111_2222_3333_4444_5555_6666, '0);
        expect_result(1, 64'h1234, 4'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data", out_data, 64'h1234);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        accept();

        // Beat without first in IDLE is discarded and flags err
        d = '1;
        send(1'b0, 1'b1, 2'd0, 2'd0, 64'd0, d, '1);
        chk("err_no_first", 64'(err), 64'd1);
        repeat (6) tick();
        chk("no_first_no_result", 64'(out_valid), 64'd0);
        chk("no_first_in_ready", 64'(in_ready), 64'd1);

        // First beat during ACCUM restarts; only new beats count
        d = {NB{8'hAA}};
        send(1'b1, 1'b0, 2'd0, 2'd0, 64'd0, d, '1);
        d2 = '0; d2[7:0] = 8'h01;
        send(1'b1, 1'b0, 2'd0, 2'd1, 64'h0100, d2, '1);
        d2 = '0; d2[23:16] = 8'h02;
        send(1'b0, 1'b1, 2'd0, 2'd0, 64'd0, d2, '1);
        expect_result(3, 64'h0103, 4'd2);
        accept();

        // flush during REDUCE, with a complete beat offered in the same cycle
        d = {NB{8'hAA}};
        send(1'b1, 1'b1, 2'd0, 2'd0, 64'd0, d, '1);
        tick();
        tick();
        flush = 1'b1;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("post_flush_out_valid", 64'(out_valid), 64'd0);
            tick();
        end
        chk("post_flush_in_ready", 64'(in_ready), 64'd1);
        chk("post_flush_err", 64'(err), 64'd1);

        // Asynchronous reset during ACCUM
        send(1'b1, 1'b0, 2'd0, 2'd0, 64'd0, d, '1);
        rst_n = 1'b0;
        #1;
        chk("arst_err", 64'(err), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_out_beats", 64'(out_beats), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Clean XOR, 16b, after reset
        d = '0;
        d[31:24] = 8'h5A;
        d[55:48] = 8'h0F;
        d[79:72] = 8'h30;
        send(1'b1, 1'b1, 2'd2, 2'd1, 64'h00FF, d, '1);
        expect_result(3, 64'h6AF0, 4'd1);
        accept();
        chk("clean_err", 64'(err), 64'd0);

        // Beat count overflow: ten beats, OR, 64b
        for (int k = 0; k < 10; k++) begin
            d = '0;
            d[k] = 1'b1;
            send(k == 0, k == 9, 2'd0, 2'd3, 64'd0, d, '1);
            if (k == 7) chk("err_at_max", 64'(err), 64'd0);
            if (k == 8) chk("err_overflow", 64'(err), 64'd1);
        end
        expect_result(1, 64'h3FF, 4'd8);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_v_red_accum.md
Name: riscv_v_red_accum

Overview:
- Sequential reduction collector on the consumer side of the vector ALU byte-vector result path.
- Accepts one or more ALU result beats of a bitwise reduction (vredor/vredand/vredxor), masks out invalid bytes and folds the beats into a byte accumulator.
- After the last beat, halves the accumulator once per cycle down to the element size, merges the scalar seed (vs1[0]) and presents one scalar result to the register-file writeback over valid/ready.

Parameters:
- NUM_BYTES, 16, bytes per ALU beat; power of two, at least 16.
- MAX_BEATS, 8, maximum beats per reduction (LMUL=8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; highest priority.
- op  in  2  0=OR, 1=AND, 2=XOR, 3=reserved (treated as OR, sets err).
- osize  in  2  element size: 0=8b, 1=16b, 2=32b, 3=64b; sampled on the first beat.
- seed  in  64  vs1[0], zero-extended; sampled on the first beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_first  in  1  first beat of a reduction.
- in_last  in  1  last beat of a reduction.
- in_data  in  NUM_BYTES*8  beat data, byte i at [8i+7:8i].
- in_bmask  in  NUM_BYTES  per-byte valid; 0 substitutes the identity value.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- out_data  out  64  reduced element, zero-extended above the element width.
- out_beats  out  $clog2(MAX_BEATS)+1  number of beats folded.
- err  out  1  sticky protocol error; cleared only by rst_n.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_beats=0, err=0, state=IDLE, accumulator all zero.
- Identity value: 8'h00 for OR/XOR, 8'hFF for AND. Masked-off bytes (in_bmask[i]=0) are replaced by the identity before folding.
- States and transitions:
  - IDLE: in_ready=1.
    - Handshake with in_first=1: accumulator := masked beat; latch op, osize, seed; beats:=1. Go to REDUCE if in_last, else ACCUM.
    - Handshake with in_first=0: beat discarded, err:=1, stay in IDLE.
  - ACCUM: in_ready=1.
    - Handshake: accumulator := accumulator op masked beat (bytewise); beats+1. Go to REDUCE if in_last.
    - in_first=1 in ACCUM: err:=1; the previous reduction is abandoned and the beat restarts it, as in IDLE.
    - Accepting a beat when beats==MAX_BEATS without in_last: err:=1; fold it anyway; beats saturates.
  - REDUCE: in_ready=0. Each cycle, acc[lower half] := lower op upper over the active width; the active width halves.
    - Runs S = log2(NUM_BYTES) - osize cycles. With NUM_BYTES=16: 8b takes 4 cycles, 64b takes 1.
    - On the final REDUCE cycle the element is combined with seed[elem width] (same op) and registered into out_data.
    - Then go to HOLD.
  - HOLD: out_valid=1. out_data and out_beats are stable until out_ready.
    - On out_ready: out_valid:=0, go to IDLE. in_ready rises the following cycle; no bypass.
- Latency: the last beat is accepted at edge t; out_valid is first high after edge t+S.
- Reduction of multiple elements within a beat: all elements of all valid bytes are combined. The result is a single element, which matches RVV vred semantics.
- flush: forces IDLE; out_valid=0 and in_ready=0 for that cycle. The accumulator is cleared, err is unchanged, and any beat presented in the same cycle is dropped.
- Reset mid-operation: immediate return to the reset values; no partial result is emitted.
- in_valid with in_ready=0: no state change, and no requirement on the source to hold the beat.
- Upper out_data bits above the element width are 0.

Decomposition:
- riscv_v_pkg:
  - red_op_e {RED_OR, RED_AND, RED_XOR}.
  - red_state_e {IDLE, ACCUM, REDUCE, HOLD}.
  - red_osize_e.
  - function red_identity(op) returning a byte.
  - RISCV_V_NUM_BYTES_DATA as the NUM_BYTES default.
- One sub-module, riscv_v_red_fold: combinational bytewise op of two NUM_BYTES vectors under a mask. It is reused by both the beat fold and the halving step.

Test Plan:
- OR, 8b, single beat (first=last), in_data bytes 01,02,04,...,80 repeated twice, bmask all ones, seed 0 -> out_data=64'hFF after 4 REDUCE cycles, out_beats=1.
- AND, 32b, two beats, bytes all FF except beat1 byte5=0xEF, bmask of beat1 = 0x00FF, seed=32'hFFFFFFFF -> out_data=64'h00000000FFFFEFFF, out_beats=2.
- XOR, 64b, bmask=0 on all beats, seed=64'h1234 -> out_data=64'h1234 after 1 REDUCE cycle.
- Backpressure: out_ready held low 5 cycles -> out_valid and out_data stable; in_ready=0 throughout; one transfer when out_ready rises.
- Protocol errors: a beat without first in IDLE -> err=1 and the beat is discarded. Then a first beat during ACCUM -> restart, and the result reflects only the new beats.
- flush asserted during REDUCE and asserting rst_n low during ACCUM -> no out_valid, return to IDLE/reset values; a following clean reduction produces the correct result.
